// File: rtl/braun_mult_pkg.sv
// Shared types and constants for the braun_mult_arbiter slice.
//   state_t    : sequencer states (MUL2 only used when BRAUN_ARB_PIPE_EN is defined)
//   DEF_*      : default requester count and operand width
//   prod_w()   : product width helper (2*WIDTH, no truncation)
package braun_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        MUL2 = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 2;
    localparam int unsigned DEF_PROD_W  = 2 * DEF_WIDTH;

    function automatic int unsigned prod_w(input int unsigned w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/braun_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter.
//   req        : request vector
//   last_grant : index of the previous winner; search starts one above it
//   enable     : when low no grant is issued
//   grant      : one-hot winner (all zero if none/disabled)
//   grant_idx  : binary index of the winner (0 when no grant)
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (enable) begin
            // Offsets 1..NUM_REQ visit every index once, last_grant itself last.
            for (int unsigned off = 1; off <= NUM_REQ; off++) begin
                idx = (32'(last_grant) + off) % NUM_REQ;
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = idx[ID_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/braun_multiplier.sv
// Combinational unsigned array multiplier.
//   a, b : WIDTH-bit unsigned operands
//   p    : 2*WIDTH-bit product, full precision
// Rows of AND-gated partial products are accumulated, each shifted by its
// multiplier bit position (the Braun array in behavioural form).
module braun_multiplier #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] acc;

    always_comb begin
        acc = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            acc = acc + ({{WIDTH{1'b0}}, a & {WIDTH{b[j]}}} << j);
        end
    end

    assign p = acc;

endmodule

// File: rtl/braun_mult_arbiter.sv
// Shares one braun_multiplier between NUM_REQ requesters.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b        : packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_p       : owner index and unsigned product
//   busy                : high whenever the sequencer is not IDLE
// Macro BRAUN_ARB_PIPE_EN adds a product register (MUL -> MUL2 -> RSP).
module braun_mult_arbiter
    import braun_mult_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter  int unsigned WIDTH   = DEF_WIDTH,
    localparam int unsigned ID_W    = $clog2(NUM_REQ),
    localparam int unsigned PW      = prod_w(WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [PW-1:0]              rsp_p,
    output logic                       busy
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [PW-1:0]     rsp_p_q, rsp_p_d;
    logic              rsp_valid_q, rsp_valid_d;
`ifdef BRAUN_ARB_PIPE_EN
    logic [PW-1:0]     prod_q, prod_d;
`endif

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [PW-1:0]      product;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .enable     (state_q == IDLE),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    braun_multiplier #(.WIDTH(WIDTH)) u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (product)
    );

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_p_d      = rsp_p_q;
        rsp_valid_d  = rsp_valid_q;
`ifdef BRAUN_ARB_PIPE_EN
        prod_d       = prod_q;
`endif
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    op_a_d       = req_a[grant_idx*WIDTH +: WIDTH];
                    op_b_d       = req_b[grant_idx*WIDTH +: WIDTH];
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = MUL;
                end
            end
`ifdef BRAUN_ARB_PIPE_EN
            MUL: begin
                prod_d  = product;
                state_d = MUL2;
            end
            MUL2: begin
                rsp_p_d     = prod_q;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
`else
            MUL: begin
                rsp_p_d     = product;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
`endif
            RSP: begin
                // No grant here even when rsp_ready is high: arbiter is
                // enabled only in IDLE.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_id_q     <= '0;
            rsp_p_q      <= '0;
            rsp_valid_q  <= 1'b0;
`ifdef BRAUN_ARB_PIPE_EN
            prod_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_p_q      <= rsp_p_d;
            rsp_valid_q  <= rsp_valid_d;
`ifdef BRAUN_ARB_PIPE_EN
            prod_q       <= prod_d;
`endif
        end
    end

endmodule

// File: tb/tb_braun_mult_arbiter.sv
// Directed bench for braun_mult_arbiter (NUM_REQ=4, WIDTH=2).
// Honours BRAUN_ARB_PIPE_EN for the expected response latency.
module tb_braun_mult_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned W  = 2;
`ifdef BRAUN_ARB_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*W-1:0]  req_a;
    logic [NR*W-1:0]  req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [2*W-1:0]   rsp_p;
    logic             busy;

    always #5 clk = ~clk;

    braun_mult_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int r;
        int a;
        int b;
        int p;
    } vec_t;

    vec_t vt[17];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input int a, input int b);
        logic [W-1:0] av, bv;
        av = W'(a);
        bv = W'(b);
        req_a[r*W +: W] = av;
        req_b[r*W +: W] = bv;
    endtask

    task automatic wait_rsp(input string tag);
        int c;
        c = 0;
        while (!rsp_valid && c < 12) begin
            tick();
            c++;
        end
        check({tag, "_rsp_timeout"}, int'(rsp_valid), 1);
    endtask

    // One isolated request: grant, one-cycle ready pulse, latency, result.
    task automatic do_txn(input int idx, input int r, input int a, input int b, input int exp_p);
        int cyc;
        req_valid = '0;
        set_req(r, a, b);
        req_valid[r] = 1'b1;
        rsp_ready = 1'b1;
        #1;
        cyc = 0;
        while (!req_ready[r] && cyc < 10) begin
            tick();
            cyc++;
        end
        check($sformatf("v%0d_grant", idx), int'(req_ready), 1 << r);
        tick();
        check($sformatf("v%0d_ready_pulse", idx), int'(req_ready), 0);
        req_valid = '0;
        cyc = 1;
        while (!rsp_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check($sformatf("v%0d_latency", idx), cyc, LAT);
        check($sformatf("v%0d_p", idx), int'(rsp_p), exp_p);
        check($sformatf("v%0d_id", idx), int'(rsp_id), r);
        tick();
        check($sformatf("v%0d_done", idx), int'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int eg[5];
        int ng, nr;

        vt[0]  = '{0, 3, 3, 9};
        vt[1]  = '{0, 0, 0, 0};
        vt[2]  = '{1, 0, 1, 0};
        vt[3]  = '{2, 0, 2, 0};
        vt[4]  = '{3, 0, 3, 0};
        vt[5]  = '{0, 1, 0, 0};
        vt[6]  = '{1, 1, 1, 1};
        vt[7]  = '{2, 1, 2, 2};
        vt[8]  = '{3, 1, 3, 3};
        vt[9]  = '{0, 2, 0, 0};
        vt[10] = '{1, 2, 1, 2};
        vt[11] = '{2, 2, 2, 4};
        vt[12] = '{3, 2, 3, 6};
        vt[13] = '{0, 3, 0, 0};
        vt[14] = '{1, 3, 1, 3};
        vt[15] = '{2, 3, 2, 6};
        vt[16] = '{3, 3, 3, 9};
        eg = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_p", int'(rsp_p), 0);
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req_ready", int'(req_ready), 0);
        rst = 1'b0;

        // Fairness: everyone requesting continuously, a=i, b=2.
        for (int unsigned i = 0; i < NR; i++) set_req(i, i, 2);
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 40 && (ng < 5 || nr < 4); c++) begin
            if (req_ready != 0 && ng < 5) begin
                check($sformatf("fair_grant%0d", ng), int'(req_ready), 1 << eg[ng]);
                ng++;
            end
            if (rsp_valid && nr < 4) begin
                check($sformatf("fair_p%0d", nr), int'(rsp_p), 2 * nr);
                check($sformatf("fair_id%0d", nr), int'(rsp_id), nr);
                nr++;
            end
            tick();
        end
        check("fair_grant_count", ng, 5);
        check("fair_rsp_count", nr, 4);
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Single request and exhaustive operand table from rotating requesters.
        for (int unsigned i = 0; i < 17; i++) begin
            do_txn(i, vt[i].r, vt[i].a, vt[i].b, vt[i].p);
        end

        // Backpressure: requester 1, 2*3, consumer stalls 5 cycles while
        // requesters 0 and 2 wait.
        rsp_ready = 1'b0;
        set_req(1, 2, 3);
        req_valid = 4'b0010;
        #1;
        check("bp_grant", int'(req_ready), 4'b0010);
        tick();
        set_req(0, 1, 1);
        set_req(2, 3, 2);
        req_valid = 4'b0101;
        #1;
        wait_rsp("bp");
        for (int unsigned k = 0; k < 5; k++) begin
            check($sformatf("bp_valid%0d", k), int'(rsp_valid), 1);
            check($sformatf("bp_p%0d", k), int'(rsp_p), 6);
            check($sformatf("bp_id%0d", k), int'(rsp_id), 1);
            check($sformatf("bp_busy%0d", k), int'(busy), 1);
            check($sformatf("bp_noready%0d", k), int'(req_ready), 0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("rsp_handshake_no_grant", int'(req_ready), 0);
        tick();
        check("bp_released", int'(rsp_valid), 0);
        check("rr_after_1", int'(req_ready), 4'b0100);
        tick();
        set_req(3, 3, 1);
        req_valid = 4'b1001;
        #1;
        check("rr_mul_noready", int'(req_ready), 0);
        wait_rsp("rr2");
        check("rr2_p", int'(rsp_p), 6);
        check("rr2_id", int'(rsp_id), 2);
        tick();
        check("rr_resume_3", int'(req_ready), 4'b1000);
        tick();
        req_valid = '0;
        wait_rsp("rr3");
        check("rr3_p", int'(rsp_p), 3);
        check("rr3_id", int'(rsp_id), 3);
        tick();

        // Reset while in MUL: request from 2 is discarded, priority restarts at 0.
        set_req(2, 3, 3);
        req_valid = 4'b0100;
        #1;
        check("rstop_grant", int'(req_ready), 4'b0100);
        tick();
        req_valid = '0;
        check("rstop_busy_mul", int'(busy), 1);
        rst = 1'b1;
        tick();
        check("rstop_valid", int'(rsp_valid), 0);
        check("rstop_busy", int'(busy), 0);
        check("rstop_p", int'(rsp_p), 0);
        check("rstop_id", int'(rsp_id), 0);
        rst = 1'b0;
        set_req(0, 2, 2);
        set_req(3, 1, 1);
        req_valid = 4'b1001;
        #1;
        check("rstop_prio0", int'(req_ready), 4'b0001);
        tick();
        req_valid = '0;
        wait_rsp("rstop");
        check("rstop_next_p", int'(rsp_p), 4);
        check("rstop_next_id", int'(rsp_id), 0);
        tick();
        check("rstop_end", int'(rsp_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
